// File: rtl/sd_slv_cmd_rx_if.sv
// rtl/sd_slv_cmd_rx_if.sv - received-command handshake between CMD receiver and command decoder
interface sd_slv_cmd_rx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        cmd_crc_err;

  // receiver side: presents the frame and waits for the decoder
  modport master (
    output cmd_valid,
    output cmd_index,
    output cmd_arg,
    output cmd_crc_err,
    input  cmd_ready
  );

  // decoder side
  modport slave (
    input  cmd_valid,
    input  cmd_index,
    input  cmd_arg,
    input  cmd_crc_err,
    output cmd_ready
  );
endinterface

// File: rtl/sd_slv_cmd_rx.sv
// rtl/sd_slv_cmd_rx.sv - SD slave CMD-line receiver: frames 48-bit host commands, sequences CRC7, checks framing
module sd_slv_cmd_rx #(
  parameter bit CHECK_TX_BIT = 1'b1,
  parameter bit DROP_BAD_CRC = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_en,
  input  logic                   bit_en,
  input  logic                   cmd_in,
  output logic                   crc_clr,
  output logic                   crc_cen,
  output logic                   crc_din,
  output logic                   crc_all_one,
  input  logic [6:0]             crc,
  sd_slv_cmd_rx_if.master        cmd,
  output logic                   frame_err,
  output logic                   crc_err,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BODY,
    S_CRC,
    S_END,
    S_HOLD
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [37:0] body_sr;
  logic [6:0]  rx_crc;
  logic [5:0]  index_q;
  logic [31:0] arg_q;
  logic        crc_flag_q;
  logic        frame_err_nxt;
  logic        crc_err_nxt;
  logic        shift_body;
  logic        shift_crc;
  logic        load_fields;
  logic        crc_mismatch;

  // The CRC unit sees every CMD bit; cen decides which ones it absorbs.
  assign crc_din     = cmd_in;
  assign crc_all_one = 1'b0;
  assign busy        = (state != S_IDLE);

  assign cmd.cmd_valid   = (state == S_HOLD);
  assign cmd.cmd_index   = index_q;
  assign cmd.cmd_arg     = arg_q;
  assign cmd.cmd_crc_err = crc_flag_q;

  // The CRC unit stops at the last body bit, so it holds the CRC of all 40 covered bits by END.
  assign crc_mismatch = (rx_crc != crc);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, CRC sequencing and datapath strobes; nothing advances without bit_en
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    frame_err_nxt = 1'b0;
    crc_err_nxt   = 1'b0;
    shift_body    = 1'b0;
    shift_crc     = 1'b0;
    load_fields   = 1'b0;
    crc_cen       = 1'b0;
    crc_clr       = 1'b0;
    case (state)
      S_IDLE: begin
        crc_clr = 1'b1;
        // Start bit is CRC-covered: release clr so the unit absorbs it this cycle.
        if (rx_en && bit_en && !cmd_in) begin
          crc_clr   = 1'b0;
          crc_cen   = 1'b1;
          state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        crc_cen = bit_en;
        if (bit_en) begin
          if (CHECK_TX_BIT && !cmd_in) begin
            frame_err_nxt = 1'b1;
            state_nxt     = S_IDLE;
          end else begin
            cnt_nxt   = 6'd0;
            state_nxt = S_BODY;
          end
        end
      end
      S_BODY: begin
        crc_cen = bit_en;
        if (bit_en) begin
          shift_body = 1'b1;
          if (cnt == 6'd37) begin
            cnt_nxt   = 6'd0;
            state_nxt = S_CRC;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
      end
      S_CRC: begin
        if (bit_en) begin
          shift_crc = 1'b1;
          if (cnt == 6'd6) begin
            cnt_nxt   = 6'd0;
            state_nxt = S_END;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
      end
      S_END: begin
        if (bit_en) begin
          if (!cmd_in) begin
            frame_err_nxt = 1'b1;
            state_nxt     = S_IDLE;
          end else begin
            crc_err_nxt = crc_mismatch;
            if (crc_mismatch && DROP_BAD_CRC) begin
              state_nxt = S_IDLE;
            end else begin
              load_fields = 1'b1;
              state_nxt   = S_HOLD;
            end
          end
        end
      end
      S_HOLD: begin
        // Bits arriving here are lost; only the decoder handshake matters.
        if (cmd.cmd_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit counter, shift registers, presented fields and registered error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= 6'd0;
      body_sr    <= 38'd0;
      rx_crc     <= 7'd0;
      index_q    <= 6'd0;
      arg_q      <= 32'd0;
      crc_flag_q <= 1'b0;
      frame_err  <= 1'b0;
      crc_err    <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      frame_err <= frame_err_nxt;
      crc_err   <= crc_err_nxt;
      if (shift_body) body_sr <= {body_sr[36:0], cmd_in};
      if (shift_crc)  rx_crc  <= {rx_crc[5:0], cmd_in};
      if (load_fields) begin
        index_q    <= body_sr[37:32];
        arg_q      <= body_sr[31:0];
        crc_flag_q <= crc_mismatch;
      end
    end
  end

endmodule

// File: tb/tb_sd_slv_cmd_rx.sv
// tb/tb_sd_slv_cmd_rx.sv - randomized self-checking bench for sd_slv_cmd_rx (keep and drop CRC variants)
module tb_sd_slv_cmd_rx;

  logic clk;
  logic rst_n;
  logic rx_en;
  logic bit_en;
  logic cmd_in;

  logic       crc_clr0, crc_cen0, crc_din0, crc_all_one0, frame_err0, crc_err0, busy0;
  logic       crc_clr1, crc_cen1, crc_din1, crc_all_one1, frame_err1, crc_err1, busy1;
  logic [6:0] crc0, crc1;

  int total = 0;
  int bad   = 0;

  int n_fe0 = 0, n_fe1 = 0, n_ce0 = 0, n_ce1 = 0, n_x0 = 0, n_x1 = 0;

  sd_slv_cmd_rx_if ifc0 ();
  sd_slv_cmd_rx_if ifc1 ();

  sd_slv_cmd_rx #(.CHECK_TX_BIT(1'b1), .DROP_BAD_CRC(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .bit_en(bit_en), .cmd_in(cmd_in),
    .crc_clr(crc_clr0), .crc_cen(crc_cen0), .crc_din(crc_din0), .crc_all_one(crc_all_one0),
    .crc(crc0), .cmd(ifc0.master), .frame_err(frame_err0), .crc_err(crc_err0), .busy(busy0)
  );

  sd_slv_cmd_rx #(.CHECK_TX_BIT(1'b1), .DROP_BAD_CRC(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .bit_en(bit_en), .cmd_in(cmd_in),
    .crc_clr(crc_clr1), .crc_cen(crc_cen1), .crc_din(crc_din1), .crc_all_one(crc_all_one1),
    .crc(crc1), .cmd(ifc1.master), .frame_err(frame_err1), .crc_err(crc_err1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial CRC7 unit the receiver drives (x^7 + x^3 + 1, clr has priority over cen)
  function automatic logic [6:0] cr7_step(input logic [6:0] c, input logic d);
    logic fb;
    fb = d ^ c[6];
    return {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  always @(posedge clk) begin
    if (!rst_n || crc_clr0) crc0 <= crc_all_one0 ? 7'h7f : 7'h00;
    else if (crc_cen0)      crc0 <= cr7_step(crc0, crc_din0);
  end

  always @(posedge clk) begin
    if (!rst_n || crc_clr1) crc1 <= crc_all_one1 ? 7'h7f : 7'h00;
    else if (crc_cen1)      crc1 <= cr7_step(crc1, crc_din1);
  end

  // Pulse and transfer counters sampled away from the active edge
  always @(negedge clk) begin
    if (frame_err0) n_fe0++;
    if (frame_err1) n_fe1++;
    if (crc_err0)   n_ce0++;
    if (crc_err1)   n_ce1++;
    if (ifc0.cmd_valid && ifc0.cmd_ready) n_x0++;
    if (ifc1.cmd_valid && ifc1.cmd_ready) n_x1++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference CRC7: remainder of M(x)*x^7 divided by x^7 + x^3 + 1, by long division
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] idx, input logic [31:0] arg,
                                             input logic tx, input logic [6:0] flip, input logic endb);
    logic [39:0] m;
    m = {1'b0, tx, idx, arg};
    return {m, crc7_ref(m) ^ flip, endb};
  endfunction

  task automatic check_reset_state();
    chk("rst_crc_clr0", crc_clr0, 1);
    chk("rst_crc_cen0", crc_cen0, 0);
    chk("rst_all_one0", crc_all_one0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_valid0", ifc0.cmd_valid, 0);
    chk("rst_index0", ifc0.cmd_index, 0);
    chk("rst_arg0", ifc0.cmd_arg, 0);
    chk("rst_crcflag0", ifc0.cmd_crc_err, 0);
    chk("rst_frame_err0", frame_err0, 0);
    chk("rst_crc_err0", crc_err0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_crc_clr1", crc_clr1, 1);
  endtask

  // Send one frame, predict every outcome from the frame bits alone, then drain with backpressure
  task automatic run_frame(input logic [47:0] f, input int gap, input int bp);
    logic        ok, exp_fe, exp_ce, p0, p1, v0e, v1e;
    int          nb, busy_bad, stable_bad;
    int          fe0s, fe1s, ce0s, ce1s, x0s, x1s;
    logic [5:0]  eidx;
    logic [31:0] earg;

    ok     = (crc7_ref(f[47:8]) == f[7:1]);
    exp_fe = !f[46] || !f[0];
    exp_ce = !exp_fe && !ok;
    p0     = !exp_fe;
    p1     = p0 && ok;
    eidx   = f[45:40];
    earg   = f[39:8];
    nb     = f[46] ? 48 : 2;

    fe0s = n_fe0; fe1s = n_fe1; ce0s = n_ce0; ce1s = n_ce1; x0s = n_x0; x1s = n_x1;
    busy_bad = 0;
    v0e = 1'b0;
    v1e = 1'b0;

    for (int i = 0; i < nb; i++) begin
      cmd_in = f[47-i];
      bit_en = 1'b1;
      @(posedge clk); #1;
      bit_en = 1'b0;
      if (i == nb - 1) begin
        v0e = ifc0.cmd_valid;
        v1e = ifc1.cmd_valid;
      end else if (!busy0) begin
        busy_bad++;
      end
      for (int j = 1; j < gap; j++) begin
        cmd_in = 1'($urandom);
        @(posedge clk); #1;
        if (i < nb - 1 && !busy0) busy_bad++;
      end
    end
    cmd_in = 1'b1;
    @(posedge clk); @(posedge clk); #1;

    chk("busy_in_frame", busy_bad, 0);
    chk("frame_err0", n_fe0 - fe0s, exp_fe);
    chk("frame_err1", n_fe1 - fe1s, exp_fe);
    chk("crc_err0", n_ce0 - ce0s, exp_ce);
    chk("crc_err1", n_ce1 - ce1s, exp_ce);
    chk("valid0_latency", v0e, p0);
    chk("valid1_latency", v1e, p1);

    if (p0) begin
      chk("index0", ifc0.cmd_index, eidx);
      chk("arg0", ifc0.cmd_arg, earg);
      chk("crcflag0", ifc0.cmd_crc_err, !ok);
      if (p1) begin
        chk("index1", ifc1.cmd_index, eidx);
        chk("arg1", ifc1.cmd_arg, earg);
        chk("crcflag1", ifc1.cmd_crc_err, 0);
      end
      rx_en = 1'b0;
      stable_bad = 0;
      repeat (bp) begin
        bit_en = 1'($urandom);
        cmd_in = 1'($urandom);
        @(posedge clk); #1;
        if (!ifc0.cmd_valid || ifc0.cmd_index !== eidx || ifc0.cmd_arg !== earg) stable_bad++;
        if (p1 && (!ifc1.cmd_valid || ifc1.cmd_index !== eidx || ifc1.cmd_arg !== earg)) stable_bad++;
      end
      bit_en = 1'b0;
      cmd_in = 1'b1;
      rx_en  = 1'b1;
      chk("hold_stable", stable_bad, 0);
      ifc0.cmd_ready = 1'b1;
      ifc1.cmd_ready = 1'b1;
      @(posedge clk); #1;
      ifc0.cmd_ready = 1'b0;
      ifc1.cmd_ready = 1'b0;
      @(posedge clk); #1;
      chk("xfer0", n_x0 - x0s, 1);
      chk("xfer1", n_x1 - x1s, p1);
      chk("valid0_after", ifc0.cmd_valid, 0);
    end
    chk("idle0", busy0, 0);
    chk("idle1", busy1, 0);
  endtask

  initial begin
    logic [47:0] f;
    int          mode;

    rst_n  = 1'b0;
    rx_en  = 1'b0;
    bit_en = 1'b0;
    cmd_in = 1'b1;
    ifc0.cmd_ready = 1'b0;
    ifc1.cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state();
    rx_en = 1'b1;

    run_frame(48'h40_0000_0000_95, 1, 0);
    run_frame(48'h48_0000_01AA_87, 4, 3);
    run_frame(make_frame(6'd17, 32'h0000_1000, 1'b1, 7'h55, 1'b1), 1, 2);
    run_frame(48'h40_0000_0000_94, 1, 0);
    run_frame(48'h00_0000_0000_95, 1, 0);
    run_frame(48'h40_0000_0000_95, 2, 10);
    run_frame(48'h48_0000_01AA_87, 1, 0);

    // Reset part-way through a frame that follows one leaving non-zero fields
    for (int i = 0; i < 20; i++) begin
      cmd_in = 1'(48'h51_0000_1000_00 >> (47 - i));
      bit_en = 1'b1;
      @(posedge clk); #1;
      bit_en = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cmd_in = 1'b1;
    check_reset_state();
    run_frame(48'h40_0000_0000_95, 1, 0);

    for (int k = 0; k < 16; k++) begin
      mode = $urandom_range(0, 9);
      case (mode)
        6, 7:    f = make_frame(6'($urandom), $urandom, 1'b1, 7'($urandom_range(1, 127)), 1'b1);
        8:       f = make_frame(6'($urandom), $urandom, 1'b1, 7'h00, 1'b0);
        9:       f = make_frame(6'($urandom), $urandom, 1'b0, 7'h00, 1'b1);
        default: f = make_frame(6'($urandom), $urandom, 1'b1, 7'h00, 1'b1);
      endcase
      run_frame(f, $urandom_range(1, 3), $urandom_range(0, 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
